arduino_fb_writer: RTL and testbench

Write side of the 40x30 2-bit frame buffer: receives pixel commands from the Arduino over the 8-bit parallel bus on `uio_in` and converts them into single-cycle writes to the frame-buffer memory. Bytes are qualified by an asynchronous strobe. Writes are issued only while the VGA timing generator reports `active` low, so they never collide with display reads. Sits beside the display-read path in the top level; the top muxes the memory address and write enable to this block whenever `active` is low.

---
 rtl/arduino_fb_writer_pkg.sv | 33 +++
 rtl/arduino_fb_writer_if.sv | 22 ++
 rtl/arduino_fb_writer_strobe_sync.sv | 30 +++
 rtl/arduino_fb_writer.sv | 175 +++++++++++++++++
 tb/tb_arduino_fb_writer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/arduino_fb_writer_pkg.sv
// arduino_fb_writer shared definitions
// frame geometry, op codes, FSM states, byte fields
package fb_pkg;

  localparam int FB_W      = 40;
  localparam int FB_H      = 30;
  localparam int FB_DEPTH  = FB_W * FB_H;
  localparam int FB_ADDR_W = 11;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_WR   = 2'b01,
    OP_FILL = 2'b10,
    OP_CLR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    HAVE_B0,
    PEND,
    FILL
  } state_e;

  localparam int B0_OP_HI = 7;
  localparam int B0_OP_LO = 6;
  localparam int B0_X_HI  = 5;
  localparam int B0_X_LO  = 0;
  localparam int B1_C_HI  = 7;
  localparam int B1_C_LO  = 6;
  localparam int B1_Y_HI  = 4;
  localparam int B1_Y_LO  = 0;

endpackage

// File: rtl/arduino_fb_writer_if.sv
// frame-buffer write port bundle
// master drives, memory mux side listens
interface arduino_fb_writer_if;
  import fb_pkg::*;

  logic [FB_ADDR_W-1:0] mem_addr;
  logic [1:0]           mem_wdata;
  logic                 mem_we;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_we
  );

  modport slave (
    input mem_addr,
    input mem_wdata,
    input mem_we
  );

endinterface

// File: rtl/arduino_fb_writer_strobe_sync.sv
// strobe synchronizer with rising-edge detect
// byte_valid is a single-cycle pulse per strobe rise
module strobe_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic byte_valid
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // shift strobe through the sync chain, keep last value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync[0] <= strobe;
      for (int i = 1; i < STAGES; i++)
        r_sync[i] <= r_sync[i-1];
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign byte_valid = r_sync[STAGES-1] & ~r_prev;

endmodule

// File: rtl/arduino_fb_writer.sv
// Arduino byte-command to frame-buffer writer
// writes only while the display is inactive
import fb_pkg::*;

module arduino_fb_writer #(
  parameter int FB_W        = 40,
  parameter int FB_H        = 30,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                strobe,
  input  logic [7:0]          bus_in,
  input  logic                active,
  arduino_fb_writer_if.master mem,
  output logic                busy,
  output logic                err_range,
  output logic                err_ovf
);

  localparam int DEPTH = FB_W * FB_H;
  localparam logic [FB_ADDR_W-1:0] LAST =
    FB_ADDR_W'(DEPTH - 1);

  logic w_bv;

  strobe_sync #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk       (clk),
    .rst       (rst),
    .strobe    (strobe),
    .byte_valid(w_bv)
  );

  state_e               r_state, w_state_nxt;
  logic [7:0]           r_b0, w_b0_nxt;
  logic [FB_ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [1:0]           r_color, w_color_nxt;
  logic [FB_ADDR_W-1:0] r_cnt, w_cnt_nxt;
  logic                 r_err_range, w_err_range_nxt;
  logic                 r_err_ovf, w_err_ovf_nxt;
  logic                 r_we, w_we_nxt;
  logic [FB_ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [1:0]           r_mem_wdata, w_mem_wdata_nxt;

  op_e                  w_op;
  logic [5:0]           w_x;
  logic [4:0]           w_y;
  logic [1:0]           w_col;
  logic                 w_in_range;
  logic [FB_ADDR_W-1:0] w_pix;
  logic                 w_unused;

  // B1 is decoded straight off the bus in its capture cycle
  assign w_op  = op_e'(r_b0[B0_OP_HI:B0_OP_LO]);
  assign w_x   = r_b0[B0_X_HI:B0_X_LO];
  assign w_y   = bus_in[B1_Y_HI:B1_Y_LO];
  assign w_col = bus_in[B1_C_HI:B1_C_LO];
  assign w_unused = bus_in[5];

  assign w_in_range = (int'(w_x) < FB_W) &&
                      (int'(w_y) < FB_H);
  assign w_pix = FB_ADDR_W'(w_y) * FB_ADDR_W'(FB_W)
               + FB_ADDR_W'(w_x);

  // next-state, flag and registered-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_b0_nxt        = r_b0;
    w_addr_nxt      = r_addr;
    w_color_nxt     = r_color;
    w_cnt_nxt       = r_cnt;
    w_err_range_nxt = r_err_range;
    w_err_ovf_nxt   = r_err_ovf;
    w_we_nxt        = 1'b0;
    w_mem_addr_nxt  = '0;
    w_mem_wdata_nxt = '0;
    unique case (r_state)
      IDLE: begin
        if (w_bv) begin
          w_b0_nxt    = bus_in;
          w_state_nxt = HAVE_B0;
        end
      end
      HAVE_B0: begin
        if (w_bv) begin
          w_state_nxt = IDLE;
          unique case (w_op)
            OP_NOP: ;
            OP_CLR: begin
              w_err_range_nxt = 1'b0;
              w_err_ovf_nxt   = 1'b0;
            end
            OP_WR: begin
              if (w_in_range) begin
                w_addr_nxt  = w_pix;
                w_color_nxt = w_col;
                w_state_nxt = PEND;
              end else begin
                w_err_range_nxt = 1'b1;
              end
            end
            OP_FILL: begin
              w_cnt_nxt   = '0;
              w_color_nxt = w_col;
              w_state_nxt = FILL;
            end
            default: ;
          endcase
        end
      end
      PEND: begin
        if (w_bv)
          w_err_ovf_nxt = 1'b1;
        if (!active) begin
          w_we_nxt        = 1'b1;
          w_mem_addr_nxt  = r_addr;
          w_mem_wdata_nxt = r_color;
          w_state_nxt     = IDLE;
        end
      end
      FILL: begin
        if (w_bv)
          w_err_ovf_nxt = 1'b1;
        if (!active) begin
          w_we_nxt        = 1'b1;
          w_mem_addr_nxt  = r_cnt;
          w_mem_wdata_nxt = r_color;
          if (r_cnt == LAST)
            w_state_nxt = IDLE;
          else
            w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // state, datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_b0        <= '0;
      r_addr      <= '0;
      r_color     <= '0;
      r_cnt       <= '0;
      r_err_range <= 1'b0;
      r_err_ovf   <= 1'b0;
      r_we        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_b0        <= w_b0_nxt;
      r_addr      <= w_addr_nxt;
      r_color     <= w_color_nxt;
      r_cnt       <= w_cnt_nxt;
      r_err_range <= w_err_range_nxt;
      r_err_ovf   <= w_err_ovf_nxt;
      r_we        <= w_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  assign mem.mem_we    = r_we;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign busy      = (r_state == PEND) ||
                     (r_state == FILL);
  assign err_range = r_err_range;
  assign err_ovf   = r_err_ovf;

endmodule

// File: tb/tb_arduino_fb_writer.sv
// arduino_fb_writer bench
// write-queue model plus directed command vectors
module tb_arduino_fb_writer;
  import fb_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       strobe;
  logic [7:0] bus_in;
  logic       active;
  logic       busy;
  logic       err_range;
  logic       err_ovf;

  arduino_fb_writer_if mem();

  arduino_fb_writer dut (
    .clk      (clk),
    .rst      (rst),
    .strobe   (strobe),
    .bus_in   (bus_in),
    .active   (active),
    .mem      (mem),
    .busy     (busy),
    .err_range(err_range),
    .err_ovf  (err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  wr_t exp_q[$];
  wr_t e;
  int  n_cmp = 0;
  int  n_bad = 0;
  int  wr_seen = 0;
  int  last_addr = -1;
  int  last_data = -1;
  int  busy_cyc = 0;
  bit  prev_act = 1'b0;
  bit  chk_en = 1'b0;
  bit  busy_chk = 1'b1;
  bit  tog_en = 1'b0;
  int  tog_cnt = 0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d",
               name, act, req);
    end
  endtask

  // compare DUT write port against the expected write queue
  always @(negedge clk) begin
    if (chk_en) begin
      if (busy === 1'b1)
        busy_cyc++;
      if (mem.mem_we === 1'b1) begin
        wr_seen++;
        last_addr = int'(mem.mem_addr);
        last_data = int'(mem.mem_wdata);
        check("we_while_active", 32'(prev_act), 0);
        check("write_expected",
              32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("wr_addr", 32'(mem.mem_addr), e.addr);
          check("wr_data", 32'(mem.mem_wdata), e.data);
          if (busy_chk)
            check("busy_on_write", 32'(busy),
                  32'(exp_q.size() > 0));
        end
      end else begin
        check("idle_addr_data",
              32'({mem.mem_addr, mem.mem_wdata}), 0);
      end
    end
    prev_act = active;
  end

  // active toggles 640 high / 160 low when enabled
  always begin
    @(posedge clk);
    #2;
    if (tog_en) begin
      active = (tog_cnt % 800) < 640;
      tog_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus_in = b;
    repeat (3) @(posedge clk);
    #2 strobe = 1'b1;
    repeat (4) @(posedge clk);
    #2 strobe = 1'b0;
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic cmd_write(input int x, input int y,
                           input int c);
    logic [7:0] b0;
    logic [7:0] b1;
    b0 = {2'b01, x[5:0]};
    b1 = {c[1:0], 1'b0, y[4:0]};
    if (x < FB_W && y < FB_H)
      exp_q.push_back('{y * FB_W + x, c});
    send_byte(b0);
    send_byte(b1);
  endtask

  task automatic push_fill(input int c);
    for (int i = 0; i < FB_DEPTH; i++)
      exp_q.push_back('{i, c});
  endtask

  task automatic chk_quiet(input string tag);
    check({tag, "_we"}, 32'(mem.mem_we), 0);
    check({tag, "_addr"}, 32'(mem.mem_addr), 0);
    check({tag, "_data"}, 32'(mem.mem_wdata), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_erange"}, 32'(err_range), 0);
    check({tag, "_eovf"}, 32'(err_ovf), 0);
  endtask

  task automatic test_basic(input string tag);
    wr_seen  = 0;
    busy_cyc = 0;
    cmd_write(5, 3, 2);
    check({tag, "_nwr"}, wr_seen, 1);
    check({tag, "_addr125"}, last_addr, 125);
    check({tag, "_data2"}, last_data, 2);
    check({tag, "_busy1cyc"}, busy_cyc, 1);
    check({tag, "_erange"}, 32'(err_range), 0);
    check({tag, "_eovf"}, 32'(err_ovf), 0);
  endtask

  initial begin
    bit found;
    rst    = 1'b1;
    strobe = 1'b0;
    active = 1'b0;
    bus_in = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    chk_quiet("reset");
    rst    = 1'b0;
    chk_en = 1'b1;

    test_basic("t1");

    wr_seen = 0;
    active  = 1'b1;
    exp_q.push_back('{3 * FB_W + 5, 2});
    send_byte(8'h45);
    bus_in = 8'h83;
    repeat (3) @(posedge clk);
    #2 strobe = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("t2_busy_after_b1", 32'(busy), 1);
    repeat (50) @(posedge clk);
    #2;
    check("t2_no_wr_active", wr_seen, 0);
    check("t2_busy_held", 32'(busy), 1);
    active = 1'b0;
    @(posedge clk);
    #2;
    check("t2_we_after_fall", 32'(mem.mem_we), 1);
    check("t2_addr", 32'(mem.mem_addr), 125);
    strobe = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("t2_nwr", wr_seen, 1);

    wr_seen = 0;
    cmd_write(40, 0, 0);
    check("t3_erange_set", 32'(err_range), 1);
    check("t3_no_wr", wr_seen, 0);
    send_byte(8'hC0);
    send_byte(8'h00);
    check("t3_erange_clr", 32'(err_range), 0);

    wr_seen = 0;
    tog_cnt = 0;
    tog_en  = 1'b1;
    push_fill(3);
    send_byte(8'h80);
    send_byte(8'hC0);
    for (int i = 0; i < 20000 && wr_seen < 300; i++)
      @(posedge clk);
    #2;
    check("t4_eovf_before", 32'(err_ovf), 0);
    send_byte(8'h55);
    check("t4_eovf_set", 32'(err_ovf), 1);
    check("t4_busy_mid", 32'(busy), 1);
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && busy == 1'b0)
        break;
    end
    check("t4_fill_left", exp_q.size(), 0);
    check("t4_fill_count", wr_seen, FB_DEPTH);
    check("t4_last_addr", last_addr, 1199);
    check("t4_last_data", last_data, 3);
    check("t4_idle", 32'(busy), 0);
    tog_en = 1'b0;
    active = 1'b0;
    repeat (4) @(posedge clk);
    #2;

    busy_chk = 1'b0;
    found    = 1'b0;
    push_fill(1);
    send_byte(8'h80);
    send_byte(8'h40);
    for (int i = 0; i < 3000; i++) begin
      if (mem.mem_we === 1'b1 &&
          mem.mem_addr == 11'd599) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #2;
    end
    check("t6_reached_600", 32'(found), 1);
    rst = 1'b1;
    while (exp_q.size() > 1)
      void'(exp_q.pop_back());
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk_quiet("t6_after_rst");
    repeat (2) @(posedge clk);
    #2;
    check("t6_no_resume", 32'(mem.mem_we), 0);
    check("t6_q_drained", exp_q.size(), 0);
    busy_chk = 1'b1;

    test_basic("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
